data_mem_responder: RTL and testbench

//   Responder for the core's data-memory port (MemWrite/Addr/WriteData out, ReadData in).

---
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind an optional store buffer (STORE_BUFFER_EN) plus LED/CYCLES/RETIRED MMIO.
// ReadData is combinational; same-cycle writes become visible only after the clock edge.
module data_mem_responder #(
    parameter int          DEPTH     = 256,
    parameter int          SB_DEPTH  = 4,
    parameter int          DRAIN_GAP = 2,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0C00
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  LED,
    output logic        SB_Full
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] ram [DEPTH];
    logic [31:0] cycles, retired, ram_rd;
    logic [29:0] word;
    logic        ram_hit, is_led, is_cyc, is_ret, ram_wr, led_wr;
    logic        unused_addr;

    assign word        = Addr[31:2];
    assign unused_addr = &{1'b0, Addr[1:0]};
    assign ram_hit     = Addr < 32'(DEPTH * 4);
    assign is_led      = word == MMIO_BASE[31:2];
    assign is_cyc      = word == MMIO_BASE[31:2] + 30'd1;
    assign is_ret      = word == MMIO_BASE[31:2] + 30'd2;
    assign ram_wr      = MemWrite & ram_hit;
    assign led_wr      = MemWrite & is_led;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            LED    <= '0;
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (led_wr) LED <= WriteData[7:0];
        end
    end

`ifdef STORE_BUFFER_EN
    localparam int PW = $clog2(SB_DEPTH);
    localparam int GW = $clog2(DRAIN_GAP + 1);

    logic [29:0]   sb_addr [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic [GW-1:0] gap;
    logic          full, drain, fwd_hit;
    logic [31:0]   fwd_data;

    assign full    = count == (PW+1)'(SB_DEPTH);
    // A store arriving into a full buffer pushes the head out on the same edge, so nothing ever stalls.
    assign drain   = (count != '0 && gap == GW'(DRAIN_GAP)) || (full && ram_wr);
    assign SB_Full = full;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            gap     <= '0;
            retired <= '0;
        end else begin
            if (drain) begin
                head    <= head + PW'(1);
                retired <= retired + 32'd1;
                gap     <= '0;
            end else if (gap != GW'(DRAIN_GAP)) begin
                gap <= gap + GW'(1);
            end
            if (ram_wr) tail <= tail + PW'(1);
            count <= count + (PW+1)'(ram_wr) - (PW+1)'(drain);
        end
    end

    // Entry storage needs no reset: validity is carried entirely by head/count.
    always_ff @(posedge CLK) begin
        if (ram_wr) begin
            sb_addr[tail] <= word;
            sb_data[tail] <= WriteData;
        end
        if (drain) ram[sb_addr[head][AW-1:0]] <= sb_data[head];
    end

    // Walk oldest to youngest so the youngest matching entry is the last assignment.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((PW+1)'(i) < count && sb_addr[head + PW'(i)] == word) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[head + PW'(i)];
            end
        end
    end

    assign ram_rd = fwd_hit ? fwd_data : ram[Addr[AW+1:2]];
`else
    assign SB_Full = 1'b0;

    always_ff @(posedge CLK) begin
        if (ram_wr && Reset_n) ram[Addr[AW+1:2]] <= WriteData;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)    retired <= '0;
        else if (ram_wr) retired <= retired + 32'd1;
    end

    assign ram_rd = ram[Addr[AW+1:2]];
`endif

    always_comb begin
        ReadData = '0;
        if (ram_hit)     ReadData = ram_rd;
        else if (is_led) ReadData = {24'h0, LED};
        else if (is_cyc) ReadData = cycles;
        else if (is_ret) ReadData = retired;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a behavioural queue model predicts reads, LED and SB_Full each cycle.
// Works for both builds (STORE_BUFFER_EN defined or not).
module tb_data_mem_responder;
    localparam logic [31:0] BASE = 32'h0000_0C00;
`ifdef STORE_BUFFER_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_write;
    logic [31:0] addr, wdata, read_data;
    logic [7:0]  led;
    logic        sb_full;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .CLK(clk), .Reset_n(rst_n), .MemWrite(mem_write), .Addr(addr),
        .WriteData(wdata), .ReadData(read_data), .LED(led), .SB_Full(sb_full)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_ram [256];
    logic [31:0] m_cycles, m_retired;
    logic [7:0]  m_led;
    int          m_g;
    logic [29:0] q_idx [$];
    logic [31:0] q_data [$];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [29:0] w;
        logic [31:0] wa;
        w  = a[31:2];
        wa = {a[31:2], 2'b00};
        if (a < 32'd1024) begin
            for (int i = q_idx.size() - 1; i >= 0; i--)
                if (q_idx[i] == w) return q_data[i];
            return m_ram[w[7:0]];
        end
        if (wa == BASE)         return {24'h0, m_led};
        if (wa == BASE + 32'd4) return m_cycles;
        if (wa == BASE + 32'd8) return m_retired;
        return 32'h0;
    endfunction

    task automatic model_reset();
        q_idx.delete();
        q_data.delete();
        m_g = 0;
        m_cycles = 0;
        m_retired = 0;
        m_led = 0;
    endtask

    task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit          ram_wr, drain;
        logic [29:0] hi;
        ram_wr = we && (a < 32'd1024);
        if (SB_EN) begin
            drain = (q_idx.size() != 0 && m_g == 2) || (q_idx.size() == 4 && ram_wr);
            if (drain) begin
                hi = q_idx.pop_front();
                m_ram[hi[7:0]] = q_data.pop_front();
                m_retired++;
                m_g = 0;
            end else if (m_g < 2) begin
                m_g++;
            end
            if (ram_wr) begin
                q_idx.push_back(a[31:2]);
                q_data.push_back(d);
            end
        end else if (ram_wr) begin
            m_ram[a[9:2]] = d;
            m_retired++;
        end
        if (we && {a[31:2], 2'b00} == BASE) m_led = d[7:0];
        m_cycles++;
    endtask

    // One cycle: drive, check pre-edge outputs, then advance the model at the edge.
    task automatic tick(input bit we, input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] e;
        logic        e_full;
        mem_write = we;
        addr      = a;
        wdata     = d;
        exp_q.push_back(model_read(a));
        #1;
        e = exp_q.pop_front();
        if (!$isunknown(e)) begin
            vectors++;
            if (read_data !== e) begin
                miscompares++;
                $display("FAIL %s read addr=%h got %h expected %h", tag, a, read_data, e);
            end
        end
        e_full = SB_EN && (q_idx.size() == 4);
        vectors++;
        if (sb_full !== e_full) begin
            miscompares++;
            $display("FAIL %s sb_full got %b expected %b", tag, sb_full, e_full);
        end
        vectors++;
        if (led !== m_led) begin
            miscompares++;
            $display("FAIL %s led got %h expected %h", tag, led, m_led);
        end
        @(posedge clk);
        model_edge(we, a, d);
        @(negedge clk);
    endtask

    task automatic settle(input logic [31:0] a, input string tag);
        repeat (12) tick(1'b0, a, 32'h0, tag);
        vectors++;
        if (q_idx.size() != 0) begin
            miscompares++;
            $display("FAIL %s drain not finished, %0d left", tag, q_idx.size());
        end
    endtask

    task automatic apply_reset(input string tag);
        rst_n     = 1'b0;
        mem_write = 1'b1;
        addr      = BASE;
        wdata     = 32'hFF;
        model_reset();
        #1;
        vectors++;
        if (led !== 8'h0 || sb_full !== 1'b0) begin
            miscompares++;
            $display("FAIL %s in reset led=%h sb_full=%b expected 00/0", tag, led, sb_full);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (led !== 8'h0 || read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL %s inputs not ignored led=%h rd=%h expected 00/0", tag, led, read_data);
        end
        mem_write = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset("reset");
        for (int i = 0; i < 4; i++) tick(1'b0, BASE + 32'd4, 32'h0, "cycles");
        tick(1'b0, BASE, 32'h0, "led_rst");
        tick(1'b0, BASE + 32'd8, 32'h0, "retired_rst");
    endtask

    task automatic test_forward();
        tick(1'b1, 32'h100, 32'hDEADBEEF, "fwd_wr");
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'h101, 32'h0, "fwd_rd");
            tick(1'b0, BASE + 32'd8, 32'h0, "fwd_ret");
        end
    endtask

    task automatic test_youngest();
        tick(1'b1, 32'h40, 32'd1, "young_wr1");
        tick(1'b1, 32'h40, 32'd2, "young_wr2");
        tick(1'b1, 32'h40, 32'd3, "young_wr3");
        tick(1'b0, 32'h40, 32'h0, "young_rd");
        settle(32'h40, "young_drain");
        tick(1'b0, BASE + 32'd8, 32'h0, "young_ret");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            tick(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), "b2b_wr");
        for (int i = 0; i < 8; i++)
            tick(1'b0, 32'(i * 4), 32'h0, "b2b_rd");
        settle(BASE + 32'd8, "b2b_drain");
        for (int i = 0; i < 8; i++)
            tick(1'b0, 32'(i * 4), 32'h0, "b2b_ram");
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h200 + 32'(i * 4), 32'h1111_0000 + 32'(i), "mid_old");
        settle(32'h200, "mid_old_drain");
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h200 + 32'(i * 4), 32'h2222_0000 + 32'(i), "mid_new");
        tick(1'b0, 32'h200, 32'h0, "mid_pre");
        apply_reset("mid_reset");
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h200 + 32'(i * 4), 32'h0, "mid_rd");
        tick(1'b0, BASE + 32'd8, 32'h0, "mid_ret");
    endtask

    task automatic test_led_mmio();
        tick(1'b1, BASE, 32'h0000_12A5, "led_wr");
        tick(1'b0, BASE, 32'h0, "led_rd");
        tick(1'b1, BASE + 32'd4, 32'h5555_5555, "ro_wr");
        tick(1'b1, BASE + 32'd8, 32'h5555_5555, "ro_wr2");
        tick(1'b1, 32'h2000, 32'h1234_5678, "drop_wr");
        tick(1'b0, 32'h2000, 32'h0, "drop_rd");
        tick(1'b0, BASE + 32'd8, 32'h0, "ret_after_ro");
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        model_reset();
        test_reset();
        test_forward();
        test_youngest();
        test_back_to_back();
        test_reset_mid_drain();
        test_led_mmio();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
